// File: rtl/fmap_collector_pkg.sv
// Shared sizing and state encoding for the layer-1 feature-map collector.
package cnn_pkg;
  localparam int W    = 13;
  localparam int L    = 10;
  localparam int P    = 6;
  localparam int PIX  = P * P;
  localparam int PIXW = $clog2(PIX);
  localparam int CHW  = $clog2(L);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    FIN   = 2'd2
  } state_e;
endpackage

// File: rtl/fmap_collector_if.sv
// Parallel capture lanes in, signed serial valid/ready stream out.
interface fmap_collector_if;
  import cnn_pkg::*;

  logic                in_valid;
  logic signed [W-1:0] in_ch [L];
  logic signed [W-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic [CHW-1:0]      out_chan;
  logic                out_last;

  modport slave (
    input  in_valid, in_ch, out_ready,
    output out_data, out_valid, out_chan, out_last
  );

  modport master (
    output in_valid, in_ch, out_ready,
    input  out_data, out_valid, out_chan, out_last
  );
endinterface

// File: rtl/fmap_collector_bank.sv
// One channel of the map: P*P samples, single write port, registered read port.
module fmap_bank
  import cnn_pkg::*;
(
  input  logic                clk,
  input  logic                we_i,
  input  logic [PIXW-1:0]     wr_addr_i,
  input  logic signed [W-1:0] wr_data_i,
  input  logic                re_i,
  input  logic [PIXW-1:0]     rd_addr_i,
  output logic signed [W-1:0] rd_data_o
);
  logic signed [W-1:0] mem_q [PIX];

  // No reset: contents are always rewritten before a drain reads them.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[wr_addr_i] <= wr_data_i;
    if (re_i) rd_data_o <= mem_q[rd_addr_i];
  end
endmodule

// File: rtl/fmap_collector.sv
// Captures L lanes x P*P pooled pixels, then replays them channel-major as one serial stream.
module fmap_collector
  import cnn_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  fmap_collector_if.slave  bus,
  output logic             done,
  output logic             ovf
);
  localparam logic [PIXW-1:0] PIX_LAST = PIXW'(PIX - 1);
  localparam logic [CHW-1:0]  CH_LAST  = CHW'(L - 1);

  state_e              state_q, state_d;
  logic [PIXW-1:0]     wr_idx_q, wr_idx_d;
  logic [PIXW-1:0]     rd_pix_q, rd_pix_d;
  logic [CHW-1:0]      rd_ch_q, rd_ch_d;
  logic                rd_done_q, rd_done_d;
  logic                s1_valid_q;
  logic [CHW-1:0]      s1_chan_q;
  logic                s1_last_q;
  logic signed [W-1:0] out_data_q;
  logic                out_valid_q;
  logic [CHW-1:0]      out_chan_q;
  logic                out_last_q;
  logic                done_q, ovf_q;

  logic                capture, issue, out_load, last_xfer;
  logic signed [W-1:0] bank_rd [L];
  logic signed [W-1:0] rd_sel;

  for (genvar c = 0; c < L; c++) begin : g_bank
    fmap_bank u_bank (
      .clk       (clk),
      .we_i      (capture),
      .wr_addr_i (wr_idx_q),
      .wr_data_i (bus.in_ch[c]),
      .re_i      (issue),
      .rd_addr_i (rd_pix_q),
      .rd_data_o (bank_rd[c])
    );
  end

  always_comb begin
    rd_sel = '0;
    for (int c = 0; c < L; c++)
      if (s1_chan_q == CHW'(c)) rd_sel = bank_rd[c];
  end

  // Read stage advances only when it is empty or the output register takes its sample.
  always_comb begin
    capture   = bus.in_valid && (state_q == FILL);
    out_load  = s1_valid_q && (!out_valid_q || bus.out_ready);
    issue     = (state_q == DRAIN) && !rd_done_q && (!s1_valid_q || out_load);
    last_xfer = out_valid_q && bus.out_ready && out_last_q;

    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    rd_pix_d  = rd_pix_q;
    rd_ch_d   = rd_ch_q;
    rd_done_d = rd_done_q;

    if (capture) wr_idx_d = wr_idx_q + PIXW'(1);
    if (issue) begin
      if (rd_pix_q == PIX_LAST) begin
        rd_pix_d = '0;
        rd_ch_d  = rd_ch_q + CHW'(1);
        if (rd_ch_q == CH_LAST) rd_done_d = 1'b1;
      end else begin
        rd_pix_d = rd_pix_q + PIXW'(1);
      end
    end

    unique case (state_q)
      FILL:    if (capture && wr_idx_q == PIX_LAST) state_d = DRAIN;
      DRAIN:   if (last_xfer) state_d = FIN;
      FIN:     state_d = FIN;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      wr_idx_q    <= '0;
      rd_pix_q    <= '0;
      rd_ch_q     <= '0;
      rd_done_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_chan_q   <= '0;
      s1_last_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_idx_q  <= wr_idx_d;
      rd_pix_q  <= rd_pix_d;
      rd_ch_q   <= rd_ch_d;
      rd_done_q <= rd_done_d;

      if (issue) begin
        s1_valid_q <= 1'b1;
        s1_chan_q  <= rd_ch_q;
        s1_last_q  <= (rd_ch_q == CH_LAST) && (rd_pix_q == PIX_LAST);
      end else if (out_load) begin
        s1_valid_q <= 1'b0;
      end

      if (out_load) begin
        out_data_q  <= rd_sel;
        out_chan_q  <= s1_chan_q;
        out_last_q  <= s1_last_q;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (last_xfer) done_q <= 1'b1;
      if (bus.in_valid && state_q != FILL) ovf_q <= 1'b1;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_last  = out_last_q;
  assign done          = done_q;
  assign ovf           = ovf_q;
endmodule

// File: tb/tb_fmap_collector.sv
// Randomized capture/drain bench for fmap_collector against a queue-based reference.
module tb_fmap_collector;
  import cnn_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic done, ovf;

  fmap_collector_if bus ();

  fmap_collector dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .done (done),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic signed [W-1:0] pix [PIX][L];
  logic [W+CHW:0]      exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_outputs",
          32'({bus.out_data, bus.out_chan, bus.out_last, bus.out_valid, done, ovf}), 32'd0);
  endtask

  // kind: 0 ramp c*100+k, 1 random, 2 sign extremes on ch0/ch9
  task automatic fill(input int kind, input bit gapped);
    exp_q.delete();
    for (int k = 0; k < PIX; k++)
      for (int c = 0; c < L; c++) begin
        case (kind)
          0:       pix[k][c] = W'(c * 100 + k);
          1:       pix[k][c] = W'($urandom);
          default: pix[k][c] = (c == 0) ? -13'sd4096 : (c == L - 1) ? 13'sd4095 : W'($urandom);
        endcase
      end
    for (int c = 0; c < L; c++)
      for (int k = 0; k < PIX; k++)
        exp_q.push_back({(c == L - 1 && k == PIX - 1), CHW'(c), pix[k][c]});

    for (int k = 0; k < PIX; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      for (int c = 0; c < L; c++) bus.in_ch[c] = pix[k][c];
      if (gapped && k < PIX - 1) begin
        for (int g = 0; g < 2; g++) begin
          @(negedge clk);
          bus.in_valid = 1'b0;
          for (int c = 0; c < L; c++) bus.in_ch[c] = W'($urandom);
          check("fill_gap_valid", 32'(bus.out_valid), 32'd0);
        end
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("lat_t", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("lat_t1", 32'(bus.out_valid), 32'd0);
  endtask

  // rmode: 0 always ready, 1 pattern 1,0,0,1, 2 random
  task automatic drain(input int rmode, input bit abuse, input int abort_at, output bit aborted);
    int             cyc = 0;
    int             nxfer = 0;
    bit             first = 1'b1;
    bit             hold = 1'b0;
    bit             abuse_seen = 1'b0;
    logic [W+CHW:0] held = '0;
    logic [W+CHW:0] cur;
    aborted = 1'b0;
    while (exp_q.size() > 0 && cyc < 3000) begin
      @(negedge clk);
      case (rmode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (abuse) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        for (int c = 0; c < L; c++) bus.in_ch[c] = W'($urandom);
        if (bus.in_valid) abuse_seen = 1'b1;
      end
      cur = {bus.out_last, bus.out_chan, bus.out_data};
      if (first) begin
        check("latency_first", 32'({bus.out_valid, cur}), 32'({1'b1, exp_q[0]}));
        first = 1'b0;
      end
      if (hold) check("stall_hold", 32'({bus.out_valid, cur}), 32'({1'b1, held}));
      hold = bus.out_valid && !bus.out_ready;
      held = cur;
      if (bus.out_valid && bus.out_ready) begin
        check("sample", 32'(cur), 32'(exp_q.pop_front()));
        nxfer++;
        if (nxfer == abort_at) begin
          @(negedge clk);
          rst = 1'b1;
          bus.out_ready = 1'b0;
          bus.in_valid  = 1'b0;
          @(negedge clk);
          check("abort_outputs",
                32'({bus.out_data, bus.out_chan, bus.out_last, bus.out_valid, done, ovf}), 32'd0);
          rst = 1'b0;
          aborted = 1'b1;
          return;
        end
      end
      cyc++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'($urandom_range(0, 1));
    check("fin_flags", 32'({bus.out_valid, done, ovf}), 32'({1'b0, 1'b1, abuse_seen}));
    check("fin_last", 32'({bus.out_last, bus.out_chan}), 32'({1'b1, CHW'(L - 1)}));
    @(negedge clk);
    check("fin_hold", 32'({bus.out_valid, done, bus.out_last}), 32'({1'b0, 1'b1, 1'b1}));
  endtask

  initial begin
    bit ab;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < L; c++) bus.in_ch[c] = '0;

    apply_reset(); fill(0, 1'b0); drain(0, 1'b0, 0, ab);
    apply_reset(); fill(0, 1'b0); drain(1, 1'b0, 0, ab);
    apply_reset(); fill(2, 1'b0); drain(2, 1'b0, 0, ab);
    apply_reset(); fill(0, 1'b1); drain(0, 1'b0, 0, ab);
    apply_reset(); fill(1, 1'b0); drain(2, 1'b1, 0, ab);
    apply_reset(); fill(1, 1'b0); drain(0, 1'b0, 50, ab);
    check("abort_taken", 32'(ab), 32'd1);
    fill(1, 1'b0); drain(2, 1'b0, 0, ab);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
